// File: rtl/amstrad_printer_port_if.sv
// Bus bundle between the CPC I/O bus / host drain side and the printer port.
// The master modport is the CPU/host side; the slave modport is the printer port itself.
interface amstrad_printer_port_if #(
  parameter int AW = 4
);
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        io_wr;
  logic        ovf_clr;
  logic        printer_busy;
  logic [6:0]  lpt_data;
  logic        lpt_valid;
  logic        lpt_ready;
  logic [AW:0] lpt_count;
  logic        lpt_overflow;

  modport master (
    output cpu_addr, cpu_dout, io_wr, ovf_clr, lpt_ready,
    input  printer_busy, lpt_data, lpt_valid, lpt_count, lpt_overflow
  );

  modport slave (
    input  cpu_addr, cpu_dout, io_wr, ovf_clr, lpt_ready,
    output printer_busy, lpt_data, lpt_valid, lpt_count, lpt_overflow
  );
endinterface

// File: rtl/amstrad_printer_port.sv
// CPC Centronics printer port: decodes OUT &EFxx, queues one byte per strobe
// rising edge into a FIFO drained over valid/ready, and drives printer BUSY.
module amstrad_printer_port #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int BUSY_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  amstrad_printer_port_if.slave  bus
);
  localparam int              TW        = (BUSY_CYCLES < 2) ? 1 : $clog2(BUSY_CYCLES + 1);
  localparam logic [AW:0]     FULL      = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [TW-1:0]   TMR_ONE   = TW'(1);
  localparam logic [TW-1:0]   BUSY_LOAD = TW'(BUSY_CYCLES);

  logic          io_wr_q;
  logic [6:0]    data_q;
  logic          strobe_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ovf_q, ovf_d;
  logic          busy_q;
  logic [6:0]    mem_q [DEPTH];

  logic sel_s, wr_pulse_s, cap_s, pop_s, push_s, drop_s;
  logic unused_s;

  // data_q mirrors the hardware latch but nothing downstream reads it.
  assign unused_s = ^{bus.cpu_addr[15:13], bus.cpu_addr[11:0], data_q};

  assign sel_s      = ~bus.cpu_addr[12];
  assign wr_pulse_s = bus.io_wr & ~io_wr_q & sel_s;
  assign cap_s      = wr_pulse_s & ~strobe_q & bus.cpu_dout[7];
  assign pop_s      = (count_q != '0) & bus.lpt_ready;
  assign push_s     = cap_s & ((count_q != FULL) | pop_s);
  assign drop_s     = cap_s & ~push_s;

  // Next-state for FIFO pointers, occupancy, BUSY timer and overflow flag.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (cap_s) begin
      timer_d = BUSY_LOAD;
    end else if (timer_q != '0) begin
      timer_d = timer_q - TMR_ONE;
    end else begin
      timer_d = timer_q;
    end

    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // io_wr_q tracks io_wr even in reset so a write held across release is not seen as new.
  always_ff @(posedge clk) begin
    if (reset) begin
      io_wr_q  <= bus.io_wr;
      data_q   <= 7'h00;
      strobe_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      io_wr_q  <= bus.io_wr;
      if (wr_pulse_s) begin
        data_q   <= bus.cpu_dout[6:0];
        strobe_q <= bus.cpu_dout[7];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      ovf_q    <= ovf_d;
      busy_q   <= (timer_d != '0) | (count_d == FULL);
    end
  end

  // FIFO storage; contents are invisible until count says otherwise, so no reset.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_q[wr_ptr_q] <= bus.cpu_dout[6:0];
    end
  end

  assign bus.lpt_data     = (count_q != '0) ? mem_q[rd_ptr_q] : 7'h00;
  assign bus.lpt_valid    = (count_q != '0);
  assign bus.lpt_count    = count_q;
  assign bus.lpt_overflow = ovf_q;
  assign bus.printer_busy = busy_q;
endmodule
